int_alu_sequencer: RTL

- Bus initiator that drives the integer ALU over the shared 256-bit memory bus. Today the testbench performs this role.
- On a start command it fetches two operands from main memory and writes them into the ALU operand registers. It then writes the opcode, waits for the ALU, reads the result and stores it back to main memory.
- Sits beside main memory and the integer ALU on the common Clk / address / nRead / nWrite / data bus. It is the only bus initiator while busy.

---
 rtl/int_alu_sequencer_if.sv | 10 +
 rtl/int_alu_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/int_alu_sequencer_if.sv
// int_alu_sequencer_if: shared memory/ALU bus as seen by the sequencer (master) and its responders (slave)
interface int_alu_sequencer_if;
  logic [15:0] address;
  logic nRead;
  logic nWrite;
  logic [255:0] DataOut;
  logic [255:0] DataIn;
  modport master(output address, nRead, nWrite, DataOut, input DataIn);
  modport slave(input address, nRead, nWrite, DataOut, output DataIn);
endinterface

// File: rtl/int_alu_sequencer.sv
// int_alu_sequencer: fetches two operands, drives the integer ALU over the bus and stores its result
module int_alu_sequencer #(
  parameter logic [15:0] ALU_BASE = 16'h1000,
  parameter int READ_LAT = 1,
  parameter int ALU_LAT = 4
) (
  input logic Clk,
  input logic Reset,
  input logic Start,
  input logic [3:0] OpCode,
  input logic [15:0] SrcA,
  input logic [15:0] SrcB,
  input logic [15:0] Dst,
  output logic Busy,
  output logic Done,
  int_alu_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, RD_A, CAP_A, WR_A, RD_B, CAP_B, WR_B, WR_OP, WAIT_ALU, RD_R, CAP_R, WR_R, DONE
  } state_t;
  state_t state, nextState;
  logic [3:0] cnt, nextCnt, opCode;
  logic [15:0] srcA, srcB, dst;
  logic [255:0] opA, opB, result;
  logic rdDone, aluDone;
  assign rdDone = cnt == 4'(READ_LAT - 1);
  assign aluDone = cnt == 4'(ALU_LAT - 1);
  assign Busy = state != IDLE && state != DONE;
  assign Done = state == DONE;
  always_comb begin
    nextState = state;
    nextCnt = '0;
    bus.nRead = 1'b1;
    bus.nWrite = 1'b1;
    bus.address = '0;
    bus.DataOut = '0;
    unique case (state)
      IDLE: nextState = Start ? RD_A : IDLE;
      RD_A: begin
        bus.nRead = 1'b0;
        bus.address = srcA;
        nextState = CAP_A;
      end
      CAP_A: begin
        nextCnt = rdDone ? '0 : cnt + 4'd1;
        nextState = rdDone ? WR_A : CAP_A;
      end
      WR_A: begin
        bus.nWrite = 1'b0;
        bus.address = ALU_BASE;
        bus.DataOut = opA;
        nextState = RD_B;
      end
      RD_B: begin
        bus.nRead = 1'b0;
        bus.address = srcB;
        nextState = CAP_B;
      end
      CAP_B: begin
        nextCnt = rdDone ? '0 : cnt + 4'd1;
        nextState = rdDone ? WR_B : CAP_B;
      end
      WR_B: begin
        bus.nWrite = 1'b0;
        bus.address = ALU_BASE + 16'd1;
        bus.DataOut = opB;
        nextState = WR_OP;
      end
      WR_OP: begin
        bus.nWrite = 1'b0;
        bus.address = ALU_BASE + 16'd2;
        bus.DataOut = {252'b0, opCode};
        nextState = WAIT_ALU;
      end
      WAIT_ALU: begin
        nextCnt = aluDone ? '0 : cnt + 4'd1;
        nextState = aluDone ? RD_R : WAIT_ALU;
      end
      RD_R: begin
        bus.nRead = 1'b0;
        bus.address = ALU_BASE + 16'd3;
        nextState = CAP_R;
      end
      CAP_R: begin
        nextCnt = rdDone ? '0 : cnt + 4'd1;
        nextState = rdDone ? WR_R : CAP_R;
      end
      WR_R: begin
        bus.nWrite = 1'b0;
        bus.address = dst;
        bus.DataOut = result;
        nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  // Command fields are frozen at Start so later input changes cannot disturb the operation in flight
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      opCode <= '0;
      srcA <= '0;
      srcB <= '0;
      dst <= '0;
      opA <= '0;
      opB <= '0;
      result <= '0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
      if (state == IDLE && Start) begin
        opCode <= OpCode;
        srcA <= SrcA;
        srcB <= SrcB;
        dst <= Dst;
      end
      if (state == CAP_A && rdDone) opA <= bus.DataIn;
      if (state == CAP_B && rdDone) opB <= bus.DataIn;
      if (state == CAP_R && rdDone) result <= bus.DataIn;
    end
endmodule
